// File: rtl/volatility_pkg.sv
// rtl/volatility_pkg.sv - shared types, default geometry and constant helpers for the volatility feeder
//
// Purpose: default feeder geometry, derived index widths, the quote record and the
// Q32.32 reciprocal helper used to publish the window constant.
// Ports: none (package).

package volatility_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_BUFFER_SIZE = 32;
  localparam int DEF_NUM_STOCKS  = 4;

  localparam int STOCK_W = $clog2(DEF_NUM_STOCKS);
  localparam int PTR_W   = $clog2(DEF_BUFFER_SIZE);
  localparam int ADDR_W  = STOCK_W + PTR_W;

  // Quote record at the default geometry.
  typedef struct packed {
    logic [STOCK_W-1:0]        stock_id;
    logic [DEF_DATA_WIDTH-1:0] bid;
    logic [DEF_DATA_WIDTH-1:0] ask;
  } quote_t;

  // 2^32 / size as a Q32.32 value; exact for power-of-two window sizes.
  function automatic logic [63:0] recip_q32(input int unsigned size);
    return 64'h0000_0001_0000_0000 / 64'(size);
  endfunction

endpackage

// File: rtl/volatility_feed_ctrl_if.sv
// rtl/volatility_feed_ctrl_if.sv - quote input and issue output handshake bundle
//
// Purpose: groups the upstream quote handshake and the downstream issue handshake.
// Signals:
//   i_valid/o_ready, i_stock_id, i_best_bid, i_best_ask   upstream quote
//   o_valid/i_out_ready, o_stock_id, o_best_bid, o_best_ask, o_write_address   downstream issue
// Modports: master = quote source / quote sink (bench side), slave = feeder.

interface volatility_feed_ctrl_if
  import volatility_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STOCK_BITS = STOCK_W,
  parameter int ADDR_BITS  = ADDR_W
);

  logic                  i_valid;
  logic                  o_ready;
  logic [STOCK_BITS-1:0] i_stock_id;
  logic [DATA_WIDTH-1:0] i_best_bid;
  logic [DATA_WIDTH-1:0] i_best_ask;

  logic                  i_out_ready;
  logic                  o_valid;
  logic [STOCK_BITS-1:0] o_stock_id;
  logic [DATA_WIDTH-1:0] o_best_bid;
  logic [DATA_WIDTH-1:0] o_best_ask;
  logic [ADDR_BITS-1:0]  o_write_address;

  modport master (
    output i_valid, i_stock_id, i_best_bid, i_best_ask, i_out_ready,
    input  o_ready, o_valid, o_stock_id, o_best_bid, o_best_ask, o_write_address
  );

  modport slave (
    input  i_valid, i_stock_id, i_best_bid, i_best_ask, i_out_ready,
    output o_ready, o_valid, o_stock_id, o_best_bid, o_best_ask, o_write_address
  );

endinterface

// File: rtl/volatility_feed_ctrl_quote_fifo.sv
// rtl/volatility_feed_ctrl_quote_fifo.sv - synchronous show-ahead FIFO for accepted quotes
//
// Purpose: small synchronous FIFO; the head entry is visible on pop_data whenever
// empty is low, so a pop and its data use the same cycle.
// Ports:
//   i_clk, i_reset_n      clock, synchronous active-low reset
//   push, push_data       write request (ignored when full)
//   pop, pop_data         read request (ignored when empty), head entry
//   count, full, empty    occupancy status

module quote_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int P_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [P_W-1:0]   wr_ptr;
  logic [P_W-1:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/volatility_feed_ctrl.sv
// rtl/volatility_feed_ctrl.sv - quote filter, buffer and history-address issuer for the volatility stage
//
// Purpose: accepts top-of-book quotes, drops empty quotes and repeats of the last
// enqueued quote per stock, buffers the rest and issues one per cycle with the
// per-stock circular history-RAM write address.
// Ports:
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   bus (slave)                 quote input handshake and issue output handshake
//   o_stock_primed              bit s set once stock s has issued a full window
//   o_buffer_size               constant window length
//   o_buffer_size_reciprocal    constant 1/window length, Q32.32
//   o_drop_count                saturating count of filtered quotes

module volatility_feed_ctrl
  import volatility_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int BUFFER_SIZE  = 32,
  parameter int NUM_STOCKS   = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  volatility_feed_ctrl_if.slave   bus,
  output logic [NUM_STOCKS-1:0]   o_stock_primed,
  output logic [DATA_WIDTH-1:0]   o_buffer_size,
  output logic [FP_WORD_SIZE-1:0] o_buffer_size_reciprocal,
  output logic [15:0]             o_drop_count
);

  localparam int STOCK_BITS = $clog2(NUM_STOCKS);
  localparam int PTR_BITS   = $clog2(BUFFER_SIZE);
  localparam int FILL_BITS  = PTR_BITS + 1;
  localparam int CNT_BITS   = $clog2(FIFO_DEPTH) + 1;
  localparam int QW         = STOCK_BITS + 2 * DATA_WIDTH;

  // Per-stock state kept in flops so every stock is readable in the same cycle.
  logic [PTR_BITS-1:0]   wr_ptr   [NUM_STOCKS];
  logic [FILL_BITS-1:0]  fill     [NUM_STOCKS];
  logic                  seen     [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_bid [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask [NUM_STOCKS];

  logic [CNT_BITS-1:0]   fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [QW-1:0]         fifo_head;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic                  accept;
  logic                  is_empty_quote;
  logic                  is_dup;
  logic                  drop;

  logic [STOCK_BITS-1:0] head_stock;
  logic [DATA_WIDTH-1:0] head_bid;
  logic [DATA_WIDTH-1:0] head_ask;

  assign o_buffer_size            = DATA_WIDTH'(BUFFER_SIZE);
  assign o_buffer_size_reciprocal = FP_WORD_SIZE'(recip_q32(BUFFER_SIZE));

  // Ready depends only on the registered occupancy, never on i_valid.
  assign bus.o_ready = (fifo_count != CNT_BITS'(FIFO_DEPTH));

  always_comb begin
    accept         = bus.i_valid && bus.o_ready;
    is_empty_quote = (bus.i_best_bid == '0) && (bus.i_best_ask == '0);
    is_dup         = seen[bus.i_stock_id]
                     && (last_bid[bus.i_stock_id] == bus.i_best_bid)
                     && (last_ask[bus.i_stock_id] == bus.i_best_ask);
    drop           = accept && (is_empty_quote || is_dup);
    fifo_push      = accept && !drop && !fifo_full;
  end

  // A held output (valid but not taken) blocks the pop; otherwise the head moves out.
  assign fifo_pop   = !fifo_empty && (!bus.o_valid || bus.i_out_ready);
  assign head_stock = fifo_head[QW-1 -: STOCK_BITS];
  assign head_bid   = fifo_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign head_ask   = fifo_head[DATA_WIDTH-1:0];

  quote_fifo #(
    .WIDTH (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_quote_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (fifo_push),
    .push_data ({bus.i_stock_id, bus.i_best_bid, bus.i_best_ask}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Filter state: duplicates are judged against the last quote that was enqueued,
  // so a dropped quote never becomes the new reference.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_drop_count <= '0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        seen[s]     <= 1'b0;
        last_bid[s] <= '0;
        last_ask[s] <= '0;
      end
    end else if (drop) begin
      if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
    end else if (fifo_push) begin
      seen[bus.i_stock_id]     <= 1'b1;
      last_bid[bus.i_stock_id] <= bus.i_best_bid;
      last_ask[bus.i_stock_id] <= bus.i_best_ask;
    end
  end

  // Issue stage: output registers plus per-stock write pointer and fill level.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_valid         <= 1'b0;
      bus.o_stock_id      <= '0;
      bus.o_best_bid      <= '0;
      bus.o_best_ask      <= '0;
      bus.o_write_address <= '0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        wr_ptr[s] <= '0;
        fill[s]   <= '0;
      end
    end else if (fifo_pop) begin
      bus.o_valid         <= 1'b1;
      bus.o_stock_id      <= head_stock;
      bus.o_best_bid      <= head_bid;
      bus.o_best_ask      <= head_ask;
      // Power-of-two window: stock*BUFFER_SIZE + ptr is a plain concatenation.
      bus.o_write_address <= {head_stock, wr_ptr[head_stock]};
      wr_ptr[head_stock]  <= wr_ptr[head_stock] + 1'b1;
      if (fill[head_stock] != FILL_BITS'(BUFFER_SIZE)) begin
        fill[head_stock] <= fill[head_stock] + 1'b1;
      end
    end else if (bus.i_out_ready) begin
      bus.o_valid <= 1'b0;
    end
  end

  always_comb begin
    o_stock_primed = '0;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      o_stock_primed[s] = (fill[s] == FILL_BITS'(BUFFER_SIZE));
    end
  end

endmodule

// File: tb/tb_volatility_feed_ctrl.sv
// tb/tb_volatility_feed_ctrl.sv - directed self-checking bench for volatility_feed_ctrl

module tb_volatility_feed_ctrl;
  import volatility_pkg::*;

  localparam int DW = 32;
  localparam int FPW = 64;
  localparam int BS = 32;
  localparam int NS = 4;
  localparam int FD = 4;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic [NS-1:0]  o_stock_primed;
  logic [DW-1:0]  o_buffer_size;
  logic [FPW-1:0] o_buffer_size_reciprocal;
  logic [15:0]    o_drop_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int stock;
    int bid;
    int ask;
    int addr;
    bit primed3;
    int cyc;
  } rec_t;
  rec_t mq[$];

  volatility_feed_ctrl_if #(.DATA_WIDTH(DW), .STOCK_BITS(STOCK_W), .ADDR_BITS(ADDR_W)) bus ();

  volatility_feed_ctrl #(
    .DATA_WIDTH   (DW),
    .FP_WORD_SIZE (FPW),
    .BUFFER_SIZE  (BS),
    .NUM_STOCKS   (NS),
    .FIFO_DEPTH   (FD)
  ) dut (
    .i_clk                    (i_clk),
    .i_reset_n                (i_reset_n),
    .bus                      (bus.slave),
    .o_stock_primed           (o_stock_primed),
    .o_buffer_size            (o_buffer_size),
    .o_buffer_size_reciprocal (o_buffer_size_reciprocal),
    .o_drop_count             (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  // Record every quote that the downstream side takes at the coming edge.
  always @(negedge i_clk) begin
    if (i_reset_n && bus.o_valid && bus.i_out_ready) begin
      mq.push_back('{int'(bus.o_stock_id), int'(bus.o_best_bid), int'(bus.o_best_ask),
                     int'(bus.o_write_address), o_stock_primed[3], cyc});
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int b, input int a);
    int n = 0;
    bus.i_valid    = 1'b1;
    bus.i_stock_id = STOCK_W'(s);
    bus.i_best_bid = DW'(b);
    bus.i_best_ask = DW'(a);
    while (!bus.o_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_ready", 64'(bus.o_ready), 64'd1);
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_issues(input string tag, input int n);
    int k = 0;
    while (mq.size() < n && k < 200) begin
      step();
      k++;
    end
    chk(tag, 64'(mq.size()), 64'(n));
  endtask

  initial begin
    bus.i_valid     = 1'b0;
    bus.i_stock_id  = '0;
    bus.i_best_bid  = '0;
    bus.i_best_ask  = '0;
    bus.i_out_ready = 1'b1;

    // Reset state and constants.
    repeat (3) step();
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_addr", 64'(bus.o_write_address), 64'd0);
    chk("rst_drop", 64'(o_drop_count), 64'd0);
    chk("rst_primed", 64'(o_stock_primed), 64'd0);
    chk("const_size", 64'(o_buffer_size), 64'd32);
    chk("const_recip", o_buffer_size_reciprocal, 64'h0000_0000_0800_0000);
    i_reset_n = 1'b1;
    step();

    // Single quote: o_valid two cycles after the accepting cycle.
    push(1, 100, 102);
    chk("lat_n1_valid", 64'(bus.o_valid), 64'd0);
    step();
    chk("lat_n2_valid", 64'(bus.o_valid), 64'd1);
    chk("first_addr", 64'(bus.o_write_address), 64'd32);
    chk("first_stock", 64'(bus.o_stock_id), 64'd1);
    chk("first_bid", 64'(bus.o_best_bid), 64'd100);
    chk("first_ask", 64'(bus.o_best_ask), 64'd102);
    chk("wr_ptr1", 64'(dut.wr_ptr[1]), 64'd1);
    chk("first_drop", 64'(o_drop_count), 64'd0);
    step();

    // Same quote presented twice more: both dropped, still only one issue.
    push(1, 100, 102);
    push(1, 100, 102);
    repeat (4) step();
    chk("dup_drop", 64'(o_drop_count), 64'd2);
    chk("dup_issues", 64'(mq.size()), 64'd1);
    push(2, 100, 102);
    repeat (3) step();
    chk("s2_issues", 64'(mq.size()), 64'd2);
    if (mq.size() == 2) begin
      chk("s2_stock", 64'(mq[1].stock), 64'd2);
      chk("s2_addr", 64'(mq[1].addr), 64'd64);
    end

    // Empty quote dropped, leaves stock 0 unseen.
    mq.delete();
    push(0, 0, 0);
    repeat (3) step();
    chk("empty_drop", 64'(o_drop_count), 64'd3);
    chk("empty_issues", 64'(mq.size()), 64'd0);
    chk("empty_seen0", 64'(dut.seen[0]), 64'd0);

    // 33 distinct quotes to stock 3: address wrap and priming.
    mq.delete();
    for (int i = 0; i < 33; i++) push(3, 1000 + i, 2000 + i);
    wait_issues("wrap_count", 33);
    repeat (2) step();
    chk("wrap_count_final", 64'(mq.size()), 64'd33);
    for (int i = 0; i < 33 && i < mq.size(); i++) begin
      chk($sformatf("wrap_addr_%0d", i), 64'(mq[i].addr), 64'(96 + (i % 32)));
      chk($sformatf("wrap_primed_%0d", i), 64'(mq[i].primed3), (i >= 31) ? 64'd1 : 64'd0);
    end
    chk("primed_vec", 64'(o_stock_primed), 64'h8);

    // Back-pressure: 5 quotes, 1 held at the output and 4 in the FIFO.
    mq.delete();
    bus.i_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 10 + i, 20 + i);
    chk("bp_ready_low", 64'(bus.o_ready), 64'd0);
    chk("bp_valid_held", 64'(bus.o_valid), 64'd1);
    chk("bp_bid_held", 64'(bus.o_best_bid), 64'd10);
    chk("bp_no_issue", 64'(mq.size()), 64'd0);
    bus.i_out_ready = 1'b1;
    wait_issues("bp_count", 5);
    repeat (3) step();
    chk("bp_count_final", 64'(mq.size()), 64'd5);
    for (int i = 0; i < 5 && i < mq.size(); i++) begin
      chk($sformatf("bp_bid_%0d", i), 64'(mq[i].bid), 64'(10 + i));
      chk($sformatf("bp_cyc_%0d", i), 64'(mq[i].cyc - mq[0].cyc), 64'(i));
    end
    chk("bp_ready_back", 64'(bus.o_ready), 64'd1);

    // Reset with quotes in flight.
    bus.i_out_ready = 1'b0;
    push(1, 300, 301);
    push(1, 302, 303);
    push(1, 304, 305);
    step();
    chk("pre_rst_valid", 64'(bus.o_valid), 64'd1);
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
    chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.o_ready), 64'd1);
    chk("mid_rst_primed", 64'(o_stock_primed), 64'd0);
    chk("mid_rst_drop", 64'(o_drop_count), 64'd0);
    mq.delete();
    bus.i_out_ready = 1'b1;
    push(3, 7, 8);
    wait_issues("post_rst_issue", 1);
    repeat (3) step();
    chk("post_rst_count", 64'(mq.size()), 64'd1);
    if (mq.size() >= 1) begin
      chk("post_rst_addr", 64'(mq[0].addr), 64'd96);
      chk("post_rst_bid", 64'(mq[0].bid), 64'd7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
